// File: rtl/router_pkg.sv
// Shared router definitions: field widths, the illegal destination code,
// the transmitter state encoding and header byte pack/unpack helpers.
package router_pkg;

   localparam int ADDR_W = 2;
   localparam int LEN_W  = 6;
   localparam int DATA_W = 8;

   localparam logic [ADDR_W-1:0] INVALID_ADDR = 2'b11;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_LOAD,
      TX_HEADER,
      TX_PAYLOAD,
      TX_PARITY,
      TX_GAP
   } tx_state_t;

   // Header byte carries the payload length in the upper bits, port in the lower bits.
   function automatic logic [DATA_W-1:0] hdr_pack(input logic [LEN_W-1:0]  len,
                                                  input logic [ADDR_W-1:0] addr);
      return {len, addr};
   endfunction

   function automatic logic [ADDR_W-1:0] hdr_addr(input logic [DATA_W-1:0] hdr);
      return hdr[ADDR_W-1:0];
   endfunction

   function automatic logic [LEN_W-1:0] hdr_len(input logic [DATA_W-1:0] hdr);
      return hdr[DATA_W-1:ADDR_W];
   endfunction

endpackage

// File: rtl/router_tx_buf.sv
// Payload buffer: 64x8 register file, one synchronous write port and one
// combinational read port. Storage is not reset; contents after reset are
// don't-care because every packet rewrites the bytes it later reads.
module router_tx_buf
   import router_pkg::*;
(
   input  logic              clk,
   input  logic              wr_en,
   input  logic [LEN_W-1:0]  wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [LEN_W-1:0]  rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [0:(1<<LEN_W)-1];

   // Write one payload byte per accepted handshake.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/router_pkt_tx.sv
// Router input-port packet transmitter. Buffers a whole packet (command plus
// payload) first, then streams header, payload and parity towards the router,
// holding each byte while the router signals busy.
module router_pkt_tx
   import router_pkg::*;
#(
   parameter int GAP = 1
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [LEN_W-1:0]  cmd_len,
   output logic              cmd_rej,
   input  logic              pl_valid,
   output logic              pl_ready,
   input  logic [DATA_W-1:0] pl_data,
   output logic              pkt_vld,
   output logic [DATA_W-1:0] tx_data,
   input  logic              busy,
   output logic              tx_done,
   output logic [7:0]        pkt_cnt
);

   localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);

   tx_state_t          state_reg;
   logic [DATA_W-1:0]  hdr_reg;
   logic [DATA_W-1:0]  par_reg;
   logic [LEN_W-1:0]   idx_reg;
   logic [GAP_W-1:0]   gap_cnt_reg;

   logic               cmd_legal;
   logic [LEN_W-1:0]   len_last;
   logic [LEN_W-1:0]   rd_addr;
   logic [DATA_W-1:0]  rd_data;

   // Handshake readiness is a pure decode of the state.
   assign cmd_ready = (state_reg == TX_IDLE);
   assign pl_ready  = (state_reg == TX_LOAD);

   assign cmd_legal = (cmd_addr != INVALID_ADDR) && (cmd_len != '0);
   assign len_last  = hdr_len(hdr_reg) - LEN_W'(1);

   // Look one byte ahead while streaming payload; the header phase fetches byte 0.
   assign rd_addr = (state_reg == TX_PAYLOAD) ? (idx_reg + LEN_W'(1)) : '0;

   router_tx_buf u_buf (
      .clk     (clk),
      .wr_en   (pl_ready && pl_valid),
      .wr_addr (idx_reg),
      .wr_data (pl_data),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   // Transmit FSM with registered router-facing outputs, parity and counters.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_reg   <= TX_IDLE;
         hdr_reg     <= '0;
         par_reg     <= '0;
         idx_reg     <= '0;
         gap_cnt_reg <= '0;
         pkt_vld     <= 1'b0;
         tx_data     <= '0;
         tx_done     <= 1'b0;
         cmd_rej     <= 1'b0;
         pkt_cnt     <= '0;
      end else begin
         tx_done <= 1'b0;
         cmd_rej <= 1'b0;
         case (state_reg)
            TX_IDLE: begin
               if (cmd_valid) begin
                  if (cmd_legal) begin
                     hdr_reg   <= hdr_pack(cmd_len, cmd_addr);
                     par_reg   <= hdr_pack(cmd_len, cmd_addr);
                     idx_reg   <= '0;
                     state_reg <= TX_LOAD;
                  end else begin
                     cmd_rej <= 1'b1;
                  end
               end
            end
            TX_LOAD: begin
               if (pl_valid) begin
                  par_reg <= par_reg ^ pl_data;
                  if (idx_reg == len_last) begin
                     pkt_vld   <= 1'b1;
                     tx_data   <= hdr_reg;
                     state_reg <= TX_HEADER;
                  end else begin
                     idx_reg <= idx_reg + LEN_W'(1);
                  end
               end
            end
            TX_HEADER: begin
               if (!busy) begin
                  tx_data   <= rd_data;
                  idx_reg   <= '0;
                  state_reg <= TX_PAYLOAD;
               end
            end
            TX_PAYLOAD: begin
               if (!busy) begin
                  if (idx_reg == len_last) begin
                     pkt_vld   <= 1'b0;
                     tx_data   <= par_reg;
                     state_reg <= TX_PARITY;
                  end else begin
                     tx_data <= rd_data;
                     idx_reg <= idx_reg + LEN_W'(1);
                  end
               end
            end
            TX_PARITY: begin
               if (!busy) begin
                  tx_data <= '0;
                  tx_done <= 1'b1;
                  pkt_cnt <= pkt_cnt + 8'd1;
                  if (GAP == 0) begin
                     state_reg <= TX_IDLE;
                  end else begin
                     gap_cnt_reg <= '0;
                     state_reg   <= TX_GAP;
                  end
               end
            end
            TX_GAP: begin
               if (gap_cnt_reg == GAP_LAST) begin
                  state_reg <= TX_IDLE;
               end else begin
                  gap_cnt_reg <= gap_cnt_reg + GAP_W'(1);
               end
            end
            default: state_reg <= TX_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Scoreboard bench for router_pkt_tx: drivers push the expected byte stream
// of each legal command, a monitor pops and compares as the DUT advances.
module tb_router_pkt_tx;

   logic       clk;
   logic       rstn;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_addr;
   logic [5:0] cmd_len;
   logic       cmd_rej;
   logic       pl_valid;
   logic       pl_ready;
   logic [7:0] pl_data;
   logic       pkt_vld;
   logic [7:0] tx_data;
   logic       busy;
   logic       tx_done;
   logic [7:0] pkt_cnt;

   typedef struct {
      logic       vld;
      logic [7:0] data;
   } exp_t;

   exp_t       exp_q[$];
   int         n_cmp;
   int         n_err;
   int         exp_cnt;
   int         busy_mode;
   logic [7:0] pl_buf [0:63];

   router_pkt_tx #(.GAP(1)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_addr  (cmd_addr),
      .cmd_len   (cmd_len),
      .cmd_rej   (cmd_rej),
      .pl_valid  (pl_valid),
      .pl_ready  (pl_ready),
      .pl_data   (pl_data),
      .pkt_vld   (pkt_vld),
      .tx_data   (tx_data),
      .busy      (busy),
      .tx_done   (tx_done),
      .pkt_cnt   (pkt_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h required %0h at %0t", nm, act, req, $time);
      end
   endtask

   task automatic fail_timeout(input string nm);
      n_cmp++;
      n_err++;
      $display("FAIL %s: timeout at %0t", nm, $time);
   endtask

   // Busy source: 0 = never busy, 1 = random, 2 = busy for 2 edges after each header appears.
   initial begin : busy_proc
      logic vld_prev;
      int   cnt;
      vld_prev = 1'b0;
      cnt      = 0;
      busy     = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (busy_mode == 1) begin
            busy = ($urandom_range(0, 2) == 0);
         end else if (busy_mode == 2) begin
            if (pkt_vld && !vld_prev) cnt = 2;
            else if (cnt > 0) cnt--;
            busy = (cnt > 0);
         end else begin
            busy = 1'b0;
         end
         vld_prev = pkt_vld;
      end
   end

   // Monitor: compares the shown byte each cycle, pops it on every advance.
   initial begin : monitor
      logic active;
      logic done_pend;
      logic ready_pend;
      exp_t e;
      active     = 1'b0;
      done_pend  = 1'b0;
      ready_pend = 1'b0;
      forever begin
         @(negedge clk);
         if (!rstn) begin
            exp_q.delete();
            active     = 1'b0;
            done_pend  = 1'b0;
            ready_pend = 1'b0;
            exp_cnt    = 0;
         end else begin
            if (ready_pend) begin
               chk("cmd_ready_after_gap", cmd_ready, 1);
               ready_pend = 1'b0;
            end
            if (done_pend) begin
               chk("tx_done_pulse", tx_done, 1);
               chk("pkt_cnt", pkt_cnt, exp_cnt[7:0]);
               chk("cmd_ready_in_gap", cmd_ready, 0);
               done_pend  = 1'b0;
               ready_pend = 1'b1;
            end else begin
               chk("tx_done_idle", tx_done, 0);
            end
            if (!active && pkt_vld) active = 1'b1;
            if (active) begin
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL unexpected_output: got vld=%0b data=%0h required nothing", pkt_vld, tx_data);
                  active = 1'b0;
               end else begin
                  chk("out_vld", pkt_vld, exp_q[0].vld);
                  chk("out_data", tx_data, exp_q[0].data);
                  chk("cmd_ready_in_pkt", cmd_ready, 0);
                  if (!busy) begin
                     e = exp_q.pop_front();
                     if (!e.vld) begin
                        active    = 1'b0;
                        done_pend = 1'b1;
                        exp_cnt   = (exp_cnt + 1) % 256;
                        $display("pkt %0d sent, parity %02h", exp_cnt, e.data);
                     end
                  end
               end
            end else begin
               chk("idle_data", tx_data, 0);
            end
         end
      end
   end

   // Offer one command and, if legal, its payload from pl_buf.
   task automatic send_cmd(input int a, input int l, input bit gaps);
      int         to;
      bit         legal;
      logic [7:0] hdr;
      logic [7:0] par;
      exp_t       e;
      to = 0;
      @(negedge clk);
      while (!cmd_ready && to < 3000) begin
         @(negedge clk);
         to++;
      end
      if (!cmd_ready) begin
         fail_timeout("cmd_ready");
         return;
      end
      legal = (a != 3) && (l != 0);
      hdr   = 8'((l * 4 + a) % 256);
      if (legal) begin
         e.vld = 1'b1; e.data = hdr; exp_q.push_back(e);
         par = hdr;
         for (int i = 0; i < l; i++) begin
            e.vld = 1'b1; e.data = pl_buf[i]; exp_q.push_back(e);
            par = par ^ pl_buf[i];
         end
         e.vld = 1'b0; e.data = par; exp_q.push_back(e);
      end
      $display("cmd addr=%0d len=%0d %s", a, l, legal ? "legal" : "illegal");
      cmd_valid = 1'b1;
      cmd_addr  = 2'(a);
      cmd_len   = 6'(l);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cmd_addr  = 2'($urandom);
      cmd_len   = 6'($urandom);
      if (!legal) begin
         chk("cmd_rej_pulse", cmd_rej, 1);
         chk("pl_ready_after_rej", pl_ready, 0);
         @(posedge clk);
         #1;
         chk("cmd_rej_clear", cmd_rej, 0);
         chk("pl_ready_rej_idle", pl_ready, 0);
         chk("pkt_cnt_after_rej", pkt_cnt, exp_cnt[7:0]);
         return;
      end
      chk("cmd_rej_legal", cmd_rej, 0);
      chk("pl_ready_load", pl_ready, 1);
      for (int i = 0; i < l; i++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               @(posedge clk);
               #1;
            end
         end
         pl_valid = 1'b1;
         pl_data  = pl_buf[i];
         @(posedge clk);
         #1;
         pl_valid = 1'b0;
         pl_data  = 8'($urandom);
      end
      chk("hdr_latency_vld", pkt_vld, 1);
      chk("hdr_latency_data", tx_data, hdr);
   endtask

   task automatic wait_idle();
      int to;
      to = 0;
      @(negedge clk);
      while ((exp_q.size() != 0 || !cmd_ready) && to < 5000) begin
         @(negedge clk);
         to++;
      end
      if (exp_q.size() != 0) fail_timeout("drain");
      repeat (3) @(negedge clk);
   endtask

   task automatic load_123();
      pl_buf[0] = 8'h11;
      pl_buf[1] = 8'h22;
      pl_buf[2] = 8'h33;
   endtask

   initial begin : watchdog
      repeat (90000) @(posedge clk);
      fail_timeout("watchdog");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin : stim
      int a;
      int l;
      n_cmp     = 0;
      n_err     = 0;
      exp_cnt   = 0;
      busy_mode = 0;
      rstn      = 1'b0;
      cmd_valid = 1'b0;
      cmd_addr  = '0;
      cmd_len   = '0;
      pl_valid  = 1'b0;
      pl_data   = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_pkt_vld", pkt_vld, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_tx_done", tx_done, 0);
      chk("rst_cmd_rej", cmd_rej, 0);
      chk("rst_pkt_cnt", pkt_cnt, 0);
      chk("rst_pl_ready", pl_ready, 0);
      chk("rst_cmd_ready", cmd_ready, 1);
      rstn = 1'b1;

      // Basic packet, then the same packet with a 2-edge stall on the header.
      load_123();
      send_cmd(1, 3, 0);
      wait_idle();
      busy_mode = 2;
      send_cmd(1, 3, 0);
      wait_idle();
      busy_mode = 0;

      // Illegal address and illegal length are dropped.
      send_cmd(3, 5, 0);
      send_cmd(1, 0, 0);
      wait_idle();

      // Maximum length with ragged payload delivery.
      for (int i = 0; i < 63; i++) pl_buf[i] = 8'(i);
      send_cmd(2, 63, 1);
      wait_idle();

      // Reset while the second payload byte is on the wire.
      load_123();
      send_cmd(1, 3, 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("pre_rst_data", tx_data, 8'h22);
      rstn = 1'b0;
      #1;
      chk("mid_rst_pkt_vld", pkt_vld, 0);
      chk("mid_rst_tx_data", tx_data, 0);
      chk("mid_rst_cmd_ready", cmd_ready, 1);
      chk("mid_rst_pkt_cnt", pkt_cnt, 0);
      @(negedge clk);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      pl_buf[0] = 8'hAA;
      send_cmd(0, 1, 0);
      wait_idle();

      // Two commands queued back to back.
      pl_buf[0] = 8'h5A; pl_buf[1] = 8'hC3;
      send_cmd(0, 2, 1);
      pl_buf[0] = 8'h01; pl_buf[1] = 8'h80; pl_buf[2] = 8'hFF; pl_buf[3] = 8'h7E;
      send_cmd(2, 4, 1);
      wait_idle();

      // Random traffic with random busy; enough packets to wrap pkt_cnt.
      busy_mode = 1;
      for (int n = 0; n < 450; n++) begin
         a = $urandom_range(0, 3);
         l = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 4);
         for (int i = 0; i < 64; i++) pl_buf[i] = 8'($urandom);
         send_cmd(a, l, $urandom_range(0, 1) == 1);
      end
      wait_idle();
      busy_mode = 0;
      repeat (4) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
